alu_lane_sel_sched: RTL and testbench

- Scheduler that shares one 8-lane x 3-bit ALU lane-select datapath between NREQ requesters.
- Round-robin arbitration over incoming commands; expands each command's op-dependent select operands into the full 8x3 select vector.
- Sequences the multi-beat ALU_BFP op; drives a single registered valid/ready output channel toward the ALU.

---
 rtl/alu_lane_sel_sched.sv | 194 +++++++++++++++++++
 tb/tb_alu_lane_sel_sched.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_lane_sel_sched.sv
// alu_lane_sel_sched: round-robin scheduler sharing one 8-lane x 3-bit ALU
// lane-select channel between NREQ requesters. Expands op-dependent select
// operands into the 24-bit select vector and sequences the 8-beat ALU_BFP op.
// Optional macro ALU_LANE_SEL_SCHED_PERF_EN adds perf_cmds/perf_stall counters.
//
// state  | meaning
// IDLE   | output register empty
// HOLD   | single-beat or final BFP beat presented
// BFP    | multi-beat BFP sequence active (beats 0..6)
module alu_lane_sel_sched #(
  parameter  int NREQ = 2,
  localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*7-1:0]    req_op,
  input  logic [NREQ*24-1:0]   req_sel_n,
  input  logic [NREQ*8-1:0]    req_sel_b,
  input  logic [NREQ*2-1:0]    req_sel_h,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [23:0]          out_sel,
  output logic [IDW-1:0]       out_src,
  output logic                 out_last,
`ifdef ALU_LANE_SEL_SCHED_PERF_EN
  output logic [31:0]          perf_cmds,
  output logic [31:0]          perf_stall,
`endif
  output logic                 busy
);

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_BFP} state_t;

  localparam logic [6:0] OP_B   = 7'd1;
  localparam logic [6:0] OP_H   = 7'd2;
  localparam logic [6:0] OP_BFP = 7'd3;

  state_t          state_q, state_d;
  logic            out_valid_q, out_valid_d;
  logic [23:0]     out_sel_q, out_sel_d;
  logic [IDW-1:0]  out_src_q, out_src_d;
  logic            out_last_q, out_last_d;
  logic [IDW-1:0]  rr_q, rr_d;
  logic [2:0]      beat_q, beat_d;

  logic            found;
  logic [IDW-1:0]  win;
  logic            accept;
  logic            hs;
  logic [6:0]      win_op;
  logic [23:0]     win_sel_n;
  logic [7:0]      win_sel_b;
  logic [1:0]      win_sel_h;
  logic [23:0]     exp_sel;
  logic [2:0]      beat_nx;

  // Round-robin search starting at the rr pointer, wrapping around
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req_valid[(int'(rr_q) + i) % NREQ]) begin
        found = 1'b1;
        win   = IDW'((int'(rr_q) + i) % NREQ);
      end
    end
  end

  assign accept    = (state_q == S_IDLE) || ((state_q == S_HOLD) && out_ready);
  assign hs        = accept && found;
  assign req_ready = (hs && !rst) ? (NREQ'(1) << win) : '0;

  assign win_op    = req_op[int'(win)*7 +: 7];
  assign win_sel_n = req_sel_n[int'(win)*24 +: 24];
  assign win_sel_b = req_sel_b[int'(win)*8 +: 8];
  assign win_sel_h = req_sel_h[int'(win)*2 +: 2];

  // Expand the winner's operands into the 8x3 lane-select vector
  always_comb begin
    exp_sel = win_sel_n;
    case (win_op)
      OP_B: begin
        for (int b = 0; b < 4; b++)
          for (int j = 0; j < 2; j++)
            exp_sel[3*(2*b+j) +: 3] = {win_sel_b[2*b +: 2], 1'(j)};
      end
      OP_H: begin
        for (int h = 0; h < 2; h++)
          for (int j = 0; j < 4; j++)
            exp_sel[3*(4*h+j) +: 3] = {win_sel_h[h], 2'(j)};
      end
      default: exp_sel = win_sel_n;
    endcase
  end

  assign beat_nx = beat_q + 3'd1;

  // Next-state and registered-output computation
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_sel_d   = out_sel_q;
    out_src_d   = out_src_q;
    out_last_d  = out_last_q;
    rr_d        = rr_q;
    beat_d      = beat_q;
    if (state_q == S_BFP) begin
      if (out_ready) begin
        beat_d    = beat_nx;
        out_sel_d = {8{beat_nx}};
        if (beat_nx == 3'd7) begin
          out_last_d = 1'b1;
          state_d    = S_HOLD;
        end
      end
    end else if (hs) begin
      out_valid_d = 1'b1;
      out_src_d   = win;
      rr_d        = IDW'((int'(win) + 1) % NREQ);
      if (win_op == OP_BFP) begin
        state_d    = S_BFP;
        beat_d     = 3'd0;
        out_sel_d  = '0;
        out_last_d = 1'b0;
      end else begin
        state_d    = S_HOLD;
        out_sel_d  = exp_sel;
        out_last_d = 1'b1;
      end
    end else if (state_q == S_HOLD && out_ready) begin
      state_d     = S_IDLE;
      out_valid_d = 1'b0;
    end
  end

  // State and output registers; reset drops any in-flight command
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      out_sel_q   <= '0;
      out_src_q   <= '0;
      out_last_q  <= 1'b0;
      rr_q        <= '0;
      beat_q      <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_sel_q   <= out_sel_d;
      out_src_q   <= out_src_d;
      out_last_q  <= out_last_d;
      rr_q        <= rr_d;
      beat_q      <= beat_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sel   = out_sel_q;
  assign out_src   = out_src_q;
  assign out_last  = out_last_q;
  assign busy      = out_valid_q | (state_q == S_BFP);

`ifdef ALU_LANE_SEL_SCHED_PERF_EN
  logic [31:0] perf_cmds_q, perf_cmds_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  // Saturating command and stall counters
  always_comb begin
    perf_cmds_d  = perf_cmds_q;
    perf_stall_d = perf_stall_q;
    if (hs && perf_cmds_q != 32'hFFFF_FFFF)
      perf_cmds_d = perf_cmds_q + 32'd1;
    if (out_valid_q && !out_ready && perf_stall_q != 32'hFFFF_FFFF)
      perf_stall_d = perf_stall_q + 32'd1;
  end

  // Counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_cmds_q  <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_cmds_q  <= perf_cmds_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_cmds  = perf_cmds_q;
  assign perf_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_alu_lane_sel_sched.sv
// Directed table-driven bench for alu_lane_sel_sched (NREQ=2), plus
// hand-written sequences for backpressure, BFP and mid-BFP reset.
module tb_alu_lane_sel_sched;

  localparam int NREQ = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_ready;
  logic [13:0] req_op = '0;
  logic [47:0] req_sel_n = '0;
  logic [15:0] req_sel_b = '0;
  logic [3:0]  req_sel_h = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [23:0] out_sel;
  logic [0:0]  out_src;
  logic        out_last;
  logic        busy;
`ifdef ALU_LANE_SEL_SCHED_PERF_EN
  logic [31:0] perf_cmds;
  logic [31:0] perf_stall;
`endif

  alu_lane_sel_sched #(.NREQ(NREQ)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_sel_n(req_sel_n),
    .req_sel_b(req_sel_b), .req_sel_h(req_sel_h),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sel(out_sel), .out_src(out_src), .out_last(out_last),
`ifdef ALU_LANE_SEL_SCHED_PERF_EN
    .perf_cmds(perf_cmds), .perf_stall(perf_stall),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  vld;
    logic [6:0]  op0, op1;
    logic [23:0] sn0, sn1;
    logic [7:0]  sb0, sb1;
    logic [1:0]  sh0, sh1;
    logic [1:0]  exp_rdy;
    logic        exp_v;
    logic [23:0] exp_sel;
    logic        exp_src;
    logic        exp_last;
  } vec_t;

  vec_t vecs[10];
  int   ncmp = 0;
  int   nerr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] vld, input logic [6:0] op0, input logic [6:0] op1,
                       input logic [23:0] sn0, input logic [23:0] sn1,
                       input logic [7:0] sb0, input logic [7:0] sb1,
                       input logic [1:0] sh0, input logic [1:0] sh1);
    req_valid = vld;
    req_op    = {op1, op0};
    req_sel_n = {sn1, sn0};
    req_sel_b = {sb1, sb0};
    req_sel_h = {sh1, sh0};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [2:0] k;
    bit done;
    // op: N=0, B=1, H=2, BFP=3
    //          vld    op0    op1    sn0         sn1         sb0    sb1    sh0    sh1    rdy    v     sel         src   last
    vecs[0] = '{2'b01, 7'd1,  7'd0,  24'h0,      24'h0,      8'hE4, 8'h00, 2'b00, 2'b00, 2'b01, 1'b1, 24'hFAC688, 1'b0, 1'b1};
    vecs[1] = '{2'b11, 7'd0,  7'd0,  24'h111111, 24'h222222, 8'h00, 8'h00, 2'b00, 2'b00, 2'b10, 1'b1, 24'h222222, 1'b1, 1'b1};
    vecs[2] = '{2'b11, 7'd0,  7'd0,  24'h111111, 24'h222222, 8'h00, 8'h00, 2'b00, 2'b00, 2'b01, 1'b1, 24'h111111, 1'b0, 1'b1};
    vecs[3] = '{2'b11, 7'd0,  7'd0,  24'h111111, 24'h222222, 8'h00, 8'h00, 2'b00, 2'b00, 2'b10, 1'b1, 24'h222222, 1'b1, 1'b1};
    vecs[4] = '{2'b00, 7'd0,  7'd0,  24'h0,      24'h0,      8'h00, 8'h00, 2'b00, 2'b00, 2'b00, 1'b0, 24'h0,      1'b0, 1'b0};
    vecs[5] = '{2'b10, 7'd0,  7'h55, 24'h0,      24'hFAC688, 8'h00, 8'h00, 2'b00, 2'b00, 2'b10, 1'b1, 24'hFAC688, 1'b1, 1'b1};
    vecs[6] = '{2'b01, 7'd2,  7'd0,  24'h0,      24'h0,      8'h00, 8'h00, 2'b10, 2'b00, 2'b01, 1'b1, 24'hFAC688, 1'b0, 1'b1};
    vecs[7] = '{2'b10, 7'd0,  7'd1,  24'h0,      24'h0,      8'h00, 8'h03, 2'b00, 2'b00, 2'b10, 1'b1, 24'h20823E, 1'b1, 1'b1};
    vecs[8] = '{2'b11, 7'd2,  7'd0,  24'h0,      24'h777777, 8'h00, 8'h00, 2'b01, 2'b00, 2'b01, 1'b1, 24'h688FAC, 1'b0, 1'b1};
    vecs[9] = '{2'b00, 7'd0,  7'd0,  24'h0,      24'h0,      8'h00, 8'h00, 2'b00, 2'b00, 2'b00, 1'b0, 24'h0,      1'b0, 1'b0};

    // Reset state
    req_valid = 2'b01;
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_sel",   32'(out_sel),   32'd0);
    chk("rst_out_src",   32'(out_src),   32'd0);
    chk("rst_out_last",  32'(out_last),  32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    #2;

    // Table of single-beat commands with out_ready held high
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].vld, vecs[i].op0, vecs[i].op1, vecs[i].sn0, vecs[i].sn1,
            vecs[i].sb0, vecs[i].sb1, vecs[i].sh0, vecs[i].sh1);
      #1;
      chk($sformatf("v%0d_req_ready", i), 32'(req_ready), 32'(vecs[i].exp_rdy));
      tick();
      chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].exp_v));
      if (vecs[i].exp_v) begin
        chk($sformatf("v%0d_out_sel", i),  32'(out_sel),  32'(vecs[i].exp_sel));
        chk($sformatf("v%0d_out_src", i),  32'(out_src),  32'(vecs[i].exp_src));
        chk($sformatf("v%0d_out_last", i), 32'(out_last), 32'(vecs[i].exp_last));
      end
    end

    // ALU_H held under backpressure, second requester waits (rr=1 now)
    out_ready = 1'b0;
    drive(2'b01, 7'd2, 7'd0, 24'h0, 24'h333333, 8'h0, 8'h0, 2'b10, 2'b00);
    #1;
    chk("h_grant", 32'(req_ready), 32'b01);
    tick();
    drive(2'b10, 7'd2, 7'd0, 24'h0, 24'h333333, 8'h0, 8'h0, 2'b10, 2'b00);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("h_stall%0d_ready", c), 32'(req_ready), 32'd0);
      chk($sformatf("h_stall%0d_valid", c), 32'(out_valid), 32'd1);
      chk($sformatf("h_stall%0d_sel", c),   32'(out_sel),   32'hFAC688);
      chk($sformatf("h_stall%0d_last", c),  32'(out_last),  32'd1);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("h_release_ready", 32'(req_ready), 32'b10);
    tick();
    chk("h_next_sel", 32'(out_sel), 32'h333333);
    chk("h_next_src", 32'(out_src), 32'd1);
    drive(2'b00, 7'd0, 7'd0, 24'h0, 24'h0, 8'h0, 8'h0, 2'b00, 2'b00);
    tick();
    chk("h_drain_valid", 32'(out_valid), 32'd0);

    // Requester 1 issues ALU_BFP (rr=0, only req1 valid), out_ready toggles
    drive(2'b10, 7'd0, 7'd3, 24'h0, 24'h0, 8'h0, 8'h0, 2'b00, 2'b00);
    #1;
    chk("bfp_grant", 32'(req_ready), 32'b10);
    tick();
    drive(2'b11, 7'd0, 7'd0, 24'h444444, 24'h0, 8'h0, 8'h0, 2'b00, 2'b00);
    k = 3'd0;
    done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      out_ready = (c % 2 == 0);
      #1;
      chk($sformatf("bfp_c%0d_ready", c), 32'(req_ready), (k == 3'd7 && out_ready) ? 32'b01 : 32'd0);
      chk($sformatf("bfp_c%0d_valid", c), 32'(out_valid), 32'd1);
      chk($sformatf("bfp_c%0d_sel", c),   32'(out_sel),   32'({8{k}}));
      chk($sformatf("bfp_c%0d_last", c),  32'(out_last),  32'(k == 3'd7));
      chk($sformatf("bfp_c%0d_src", c),   32'(out_src),   32'd1);
      chk($sformatf("bfp_c%0d_busy", c),  32'(busy),      32'd1);
      tick();
      if (out_ready) begin
        if (k == 3'd7) done = 1'b1;
        else k = k + 3'd1;
      end
    end
    chk("bfp_completed", 32'(done), 32'd1);
    chk("bfp_next_sel", 32'(out_sel), 32'h444444);
    chk("bfp_next_src", 32'(out_src), 32'd0);
    chk("bfp_next_last", 32'(out_last), 32'd1);
    out_ready = 1'b1;
    drive(2'b00, 7'd0, 7'd0, 24'h0, 24'h0, 8'h0, 8'h0, 2'b00, 2'b00);
    tick();

    // Reset asserted at BFP beat 3 (rr=1 before reset)
    drive(2'b01, 7'd3, 7'd0, 24'h0, 24'h0, 8'h0, 8'h0, 2'b00, 2'b00);
    #1;
    chk("rbfp_grant", 32'(req_ready), 32'b01);
    tick();
    drive(2'b00, 7'd0, 7'd0, 24'h0, 24'h0, 8'h0, 8'h0, 2'b00, 2'b00);
    tick(); tick(); tick();
    chk("rbfp_beat3_sel", 32'(out_sel), 32'h6DB6DB);
    chk("rbfp_beat3_busy", 32'(busy), 32'd1);
    req_valid = 2'b01;
    #2;
    rst = 1'b1;
    #1;
    chk("rbfp_valid", 32'(out_valid), 32'd0);
    chk("rbfp_busy",  32'(busy),      32'd0);
    chk("rbfp_last",  32'(out_last),  32'd0);
    chk("rbfp_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(2'b11, 7'd0, 7'd0, 24'h555555, 24'h666666, 8'h0, 8'h0, 2'b00, 2'b00);
    #1;
    chk("post_rst_grant", 32'(req_ready), 32'b01);
    tick();
    chk("post_rst_sel",  32'(out_sel),  32'h555555);
    chk("post_rst_src",  32'(out_src),  32'd0);
    chk("post_rst_last", 32'(out_last), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", ncmp, nerr);
    $finish;
  end

endmodule
